// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU op codes, immediate formats
// and the control bundle carried through the ID/EX register.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_wr;
    logic    mem_rd;
    logic    mem_wr;
    logic    mem_to_reg;
    logic    branch;
    logic    jump;
  } ctrl_t;

  // funct3/funct7 to ALU op for OP and OP-IMM; SUB exists only in OP form
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3,
                                             input logic funct7_b5,
                                             input logic is_reg_op);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_reg_op && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32x32 register file: two combinational read ports with write-through,
// one write port, x0 hardwired to zero, all entries cleared on reset.
module riscv_regfile
  import riscv_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic [4:0]           rd_addr1,
  input  logic [4:0]           rd_addr2,
  output logic [WORD_SIZE-1:0] rd_data1,
  output logic [WORD_SIZE-1:0] rd_data2
);

  logic [WORD_SIZE-1:0] regs [REG_COUNT];
  logic                 wr_live;

  assign wr_live = wr_en && (wr_addr != 5'd0);

  // storage update; x0 is never written so it stays at its reset value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // read ports: x0 forced to zero, same-cycle write bypasses storage
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rd_addr1 != 5'd0) rd_data1 = (wr_live && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1];
    if (rd_addr2 != 5'd0) rd_data2 = (wr_live && wr_addr == rd_addr2) ? wr_data : regs[rd_addr2];
  end

endmodule

// File: rtl/riscv_id_stage.sv
// RV32I decode stage: decodes control and immediate, reads the register
// file, detects load-use hazards and drives the ID/EX pipeline register.
module riscv_id_stage
  import riscv_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WORD_SIZE-1:0] PC_IF_i,
  input  logic [WORD_SIZE-1:0] instr_IF_i,
  input  logic                 flush_i,
  input  logic                 wb_en_i,
  input  logic [4:0]           wb_rd_i,
  input  logic [WORD_SIZE-1:0] wb_data_i,
  output logic                 stall_o,
  output logic [WORD_SIZE-1:0] PC_ID_o,
  output logic [WORD_SIZE-1:0] rs1_data_o,
  output logic [WORD_SIZE-1:0] rs2_data_o,
  output logic [WORD_SIZE-1:0] imm_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [4:0]           rd_o,
  output logic [2:0]           funct3_o,
  output logic [3:0]           alu_op_o,
  output logic                 alu_src_o,
  output logic                 reg_wr_o,
  output logic                 mem_rd_o,
  output logic                 mem_wr_o,
  output logic                 mem_to_reg_o,
  output logic                 branch_o,
  output logic                 jump_o,
  output logic                 illegal_o
);

  logic [6:0]           opcode;
  logic [4:0]           rs1, rs2, rd;
  logic [2:0]           funct3;
  logic [WORD_SIZE-1:0] rs1_data, rs2_data, imm;
  ctrl_t                dec_ctrl, ctrl_q;
  imm_type_e            imm_type;
  logic                 dec_illegal, rs2_used, stall, bubble;

  assign opcode = instr_IF_i[6:0];
  assign rd     = instr_IF_i[11:7];
  assign funct3 = instr_IF_i[14:12];
  assign rs1    = instr_IF_i[19:15];
  assign rs2    = instr_IF_i[24:20];

  riscv_regfile #(
    .WORD_SIZE (WORD_SIZE),
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clk      (clk_i),
    .rst      (rst_i),
    .wr_en    (wb_en_i),
    .wr_addr  (wb_rd_i),
    .wr_data  (wb_data_i),
    .rd_addr1 (rs1),
    .rd_addr2 (rs2),
    .rd_data1 (rs1_data),
    .rd_data2 (rs2_data)
  );

  // opcode decode into control bundle, immediate format and rs2 usage
  always_comb begin
    dec_ctrl    = '0;
    imm_type    = IMM_NONE;
    dec_illegal = 1'b0;
    rs2_used    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm_type = IMM_U;
        dec_ctrl.alu_op  = ALU_PASSB;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.reg_wr  = 1'b1;
      end
      OPC_AUIPC: begin
        imm_type = IMM_U;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.reg_wr  = 1'b1;
      end
      OPC_JAL: begin
        imm_type = IMM_J;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.reg_wr  = 1'b1;
        dec_ctrl.jump    = 1'b1;
      end
      OPC_JALR: begin
        imm_type = IMM_I;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.reg_wr  = 1'b1;
        dec_ctrl.jump    = 1'b1;
      end
      OPC_BRANCH: begin
        imm_type = IMM_B;
        rs2_used = 1'b1;
        dec_ctrl.alu_op = ALU_SUB;
        dec_ctrl.branch = 1'b1;
      end
      OPC_LOAD: begin
        imm_type = IMM_I;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.reg_wr     = 1'b1;
        dec_ctrl.mem_rd     = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        rs2_used = 1'b1;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.mem_wr  = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_type = IMM_I;
        dec_ctrl.alu_op  = alu_from_funct(funct3, instr_IF_i[30], 1'b0);
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.reg_wr  = 1'b1;
      end
      OPC_OP: begin
        rs2_used = 1'b1;
        dec_ctrl.alu_op = alu_from_funct(funct3, instr_IF_i[30], 1'b1);
        dec_ctrl.reg_wr = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // immediate assembly, sign-extended from instruction bit 31
  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{instr_IF_i[31]}}, instr_IF_i[31:20]};
      IMM_S:   imm = {{20{instr_IF_i[31]}}, instr_IF_i[31:25], instr_IF_i[11:7]};
      IMM_B:   imm = {{20{instr_IF_i[31]}}, instr_IF_i[7], instr_IF_i[30:25],
                      instr_IF_i[11:8], 1'b0};
      IMM_U:   imm = {instr_IF_i[31:12], 12'b0};
      IMM_J:   imm = {{12{instr_IF_i[31]}}, instr_IF_i[19:12], instr_IF_i[20],
                      instr_IF_i[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // load-use hazard against the load currently sitting in ID/EX
  always_comb begin
    stall = 1'b0;
    if (ctrl_q.mem_rd && rd_o != 5'd0 && !flush_i && !rst_i)
      stall = (rd_o == rs1) || (rs2_used && rd_o == rs2);
  end

  assign stall_o = stall;
  assign bubble  = flush_i || stall || dec_illegal;

  // ID/EX register: flush, then stall, then illegal opcode all insert a bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      illegal_o  <= 1'b0;
      PC_ID_o    <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      rs1_o      <= '0;
      rs2_o      <= '0;
      rd_o       <= '0;
      funct3_o   <= '0;
    end else begin
      ctrl_q     <= bubble ? '0 : dec_ctrl;
      illegal_o  <= dec_illegal && !flush_i && !stall;
      PC_ID_o    <= bubble ? '0 : PC_IF_i;
      rs1_data_o <= bubble ? '0 : rs1_data;
      rs2_data_o <= bubble ? '0 : rs2_data;
      imm_o      <= bubble ? '0 : imm;
      rs1_o      <= bubble ? '0 : rs1;
      rs2_o      <= bubble ? '0 : rs2;
      rd_o       <= bubble ? '0 : rd;
      funct3_o   <= bubble ? '0 : funct3;
    end
  end

  assign alu_op_o     = ctrl_q.alu_op;
  assign alu_src_o    = ctrl_q.alu_src;
  assign reg_wr_o     = ctrl_q.reg_wr;
  assign mem_rd_o     = ctrl_q.mem_rd;
  assign mem_wr_o     = ctrl_q.mem_wr;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign branch_o     = ctrl_q.branch;
  assign jump_o       = ctrl_q.jump;

endmodule

// File: tb/tb_riscv_id_stage.sv
// Bench for riscv_id_stage: directed cases with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_riscv_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, instr, wb_data;
  logic        flush, wb_en;
  logic [4:0]  wb_rd;

  logic        stall_o, alu_src_o, reg_wr_o, mem_rd_o, mem_wr_o, mem_to_reg_o;
  logic        branch_o, jump_o, illegal_o;
  logic [31:0] PC_ID_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  funct3_o;
  logic [3:0]  alu_op_o;

  int total = 0;
  int bad   = 0;
  bit go    = 1'b0;
  bit stalled = 1'b0;

  always #5 clk = ~clk;

  riscv_id_stage dut (
    .clk_i(clk), .rst_i(rst), .PC_IF_i(pc), .instr_IF_i(instr),
    .flush_i(flush), .wb_en_i(wb_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .stall_o(stall_o), .PC_ID_o(PC_ID_o), .rs1_data_o(rs1_data_o),
    .rs2_data_o(rs2_data_o), .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rd_o(rd_o), .funct3_o(funct3_o), .alu_op_o(alu_op_o), .alu_src_o(alu_src_o),
    .reg_wr_o(reg_wr_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .mem_to_reg_o(mem_to_reg_o), .branch_o(branch_o), .jump_o(jump_o),
    .illegal_o(illegal_o)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        alusrc, regwr, memrd, memwr, m2r, br, jmp, ill;
  } out_t;

  localparam logic [3:0] A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3, A_SLTU = 4,
                         A_XOR = 5, A_SRL = 6, A_SRA = 7, A_OR = 8, A_AND = 9, A_PASSB = 10;

  logic [31:0] mregs [32];
  out_t        exp_q;

  function automatic logic [31:0] reg_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_en && wb_rd == a) return wb_data;
    return mregs[a];
  endfunction

  function automatic logic model_stall();
    logic [4:0] s1, s2;
    logic       uses2;
    s1 = instr[19:15];
    s2 = instr[24:20];
    uses2 = (instr[6:0] == 7'h63) || (instr[6:0] == 7'h23) || (instr[6:0] == 7'h33);
    if (rst || flush || !exp_q.memrd || exp_q.rd == 0) return 1'b0;
    return (exp_q.rd == s1) || (uses2 && exp_q.rd == s2);
  endfunction

  function automatic out_t predict();
    out_t o;
    logic [31:0] i;
    logic [3:0]  f3_alu [8];
    i = instr;
    o = '0;
    f3_alu = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    if (flush || model_stall()) return o;
    o.pc = pc; o.rs1 = i[19:15]; o.rs2 = i[24:20]; o.rd = i[11:7]; o.f3 = i[14:12];
    o.rs1d = reg_read(i[19:15]); o.rs2d = reg_read(i[24:20]);
    case (i[6:0])
      7'h37: begin o.imm = i & 32'hFFFFF000; o.alu = A_PASSB; o.alusrc = 1; o.regwr = 1; end
      7'h17: begin o.imm = i & 32'hFFFFF000; o.alu = A_ADD; o.alusrc = 1; o.regwr = 1; end
      7'h6F: begin
        o.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        o.alusrc = 1; o.regwr = 1; o.jmp = 1;
      end
      7'h67: begin o.imm = $signed(i) >>> 20; o.alusrc = 1; o.regwr = 1; o.jmp = 1; end
      7'h63: begin
        o.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        o.alu = A_SUB; o.br = 1;
      end
      7'h03: begin o.imm = $signed(i) >>> 20; o.alusrc = 1; o.regwr = 1; o.memrd = 1; o.m2r = 1; end
      7'h23: begin
        o.imm = $signed(i) >>> 20;
        o.imm[4:0] = i[11:7];
        o.alusrc = 1; o.memwr = 1;
      end
      7'h13: begin
        o.imm = $signed(i) >>> 20; o.alusrc = 1; o.regwr = 1;
        o.alu = f3_alu[i[14:12]];
        if (i[14:12] == 3'b101 && i[30]) o.alu = A_SRA;
      end
      7'h33: begin
        o.regwr = 1;
        o.alu = f3_alu[i[14:12]];
        if (i[30] && i[14:12] == 3'b000) o.alu = A_SUB;
        if (i[30] && i[14:12] == 3'b101) o.alu = A_SRA;
      end
      default: begin o = '0; o.ill = 1; end
    endcase
    return o;
  endfunction

  // model state advance: ID/EX register image and architectural registers
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
      for (int k = 0; k < 32; k++) mregs[k] <= 32'd0;
    end else begin
      exp_q <= predict();
      if (wb_en && wb_rd != 0) mregs[wb_rd] <= wb_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, want);
    end
  endtask

  // per-cycle comparison of every output against the model
  initial begin
    out_t e;
    wait (go);
    forever begin
      @(negedge clk);
      #2;
      e = rst ? '0 : exp_q;
      chk("stall",    32'(stall_o),      32'(model_stall()));
      chk("pc",       PC_ID_o,           e.pc);
      chk("rs1_data", rs1_data_o,        e.rs1d);
      chk("rs2_data", rs2_data_o,        e.rs2d);
      chk("imm",      imm_o,             e.imm);
      chk("rs1",      32'(rs1_o),        32'(e.rs1));
      chk("rs2",      32'(rs2_o),        32'(e.rs2));
      chk("rd",       32'(rd_o),         32'(e.rd));
      chk("funct3",   32'(funct3_o),     32'(e.f3));
      chk("alu_op",   32'(alu_op_o),     32'(e.alu));
      chk("alu_src",  32'(alu_src_o),    32'(e.alusrc));
      chk("reg_wr",   32'(reg_wr_o),     32'(e.regwr));
      chk("mem_rd",   32'(mem_rd_o),     32'(e.memrd));
      chk("mem_wr",   32'(mem_wr_o),     32'(e.memwr));
      chk("mem2reg",  32'(mem_to_reg_o), 32'(e.m2r));
      chk("branch",   32'(branch_o),     32'(e.br));
      chk("jump",     32'(jump_o),       32'(e.jmp));
      chk("illegal",  32'(illegal_o),    32'(e.ill));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic fl, input logic [31:0] ins,
                       input logic [31:0] pcv, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd);
    @(negedge clk);
    rst = r; flush = fl; instr = ins; pc = pcv;
    wb_en = we; wb_rd = wr; wb_data = wd;
    #3;
    stalled = stall_o;
  endtask

  task automatic step(input logic [31:0] ins);
    drive(1'b0, 1'b0, ins, 32'h0000_0200, 1'b0, 5'd0, 32'd0);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  op;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: op = 7'h37; 1: op = 7'h17; 2: op = 7'h6F; 3: op = 7'h67;
      4: op = 7'h63; 5, 6: op = 7'h03; 7: op = 7'h23; 8: op = 7'h13;
      9, 10: op = 7'h33;
      default: case ($urandom_range(0, 3))
        0: op = 7'h7F; 1: op = 7'h0F; 2: op = 7'h73; default: op = 7'h00;
      endcase
    endcase
    w[6:0]   = op;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if (op == 7'h33) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  localparam logic [31:0] NOPI = 32'h00000013;
  localparam logic [31:0] LW5  = 32'h0000A283;
  localparam logic [31:0] ADD6 = 32'h00028333;

  initial begin
    logic [31:0] ins;
    rst = 1'b1; flush = 1'b0; instr = NOPI; pc = 32'd0;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    drive(1'b1, 1'b0, NOPI, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 1'b0, NOPI, 32'd0, 1'b0, 5'd0, 32'd0);
    go = 1'b1;

    // addi x1,x0,5
    drive(1'b0, 1'b0, 32'h00500093, 32'h0000_0100, 1'b0, 5'd0, 32'd0);
    step(NOPI);
    chk("lit_addi_rd",  32'(rd_o), 32'd1);
    chk("lit_addi_imm", imm_o, 32'd5);
    chk("lit_addi_wr",  32'(reg_wr_o), 32'd1);
    chk("lit_addi_src", 32'(alu_src_o), 32'd1);
    chk("lit_addi_alu", 32'(alu_op_o), 32'(A_ADD));
    chk("lit_addi_pc",  PC_ID_o, 32'h0000_0100);

    // x1 gets data, then reset mid-stream must wipe it
    drive(1'b0, 1'b0, NOPI, 32'd0, 1'b1, 5'd1, 32'h1234);
    step(32'h001081B3);
    step(NOPI);
    chk("lit_x1_before_rst", rs1_data_o, 32'h1234);
    drive(1'b1, 1'b0, LW5, 32'h40, 1'b0, 5'd0, 32'd0);
    chk("lit_rst_regwr", 32'(reg_wr_o), 32'd0);
    chk("lit_rst_data",  rs1_data_o, 32'd0);
    chk("lit_rst_stall", 32'(stall_o), 32'd0);
    step(32'h001081B3);
    step(NOPI);
    chk("lit_x1_after_rst", rs1_data_o, 32'd0);

    // write-through on add x3,x2,x2
    drive(1'b0, 1'b0, 32'h002101B3, 32'h80, 1'b1, 5'd2, 32'hDEADBEEF);
    step(NOPI);
    chk("lit_wt_rs1", rs1_data_o, 32'hDEADBEEF);
    chk("lit_wt_rs2", rs2_data_o, 32'hDEADBEEF);

    // x0 stays zero; beq x0,x0,-4
    drive(1'b0, 1'b0, NOPI, 32'd0, 1'b1, 5'd0, 32'hFFFF);
    drive(1'b0, 1'b0, 32'h000001B3, 32'd0, 1'b1, 5'd0, 32'hFFFF);
    step(32'hFE000EE3);
    chk("lit_x0_rs1", rs1_data_o, 32'd0);
    step(NOPI);
    chk("lit_beq_imm", imm_o, 32'hFFFFFFFC);
    chk("lit_beq_br",  32'(branch_o), 32'd1);

    // load-use: one stall cycle, one bubble, then add issues
    step(LW5);
    step(ADD6);
    chk("lit_lu_stall", 32'(stall_o), 32'd1);
    step(ADD6);
    chk("lit_lu_stall_gone", 32'(stall_o), 32'd0);
    chk("lit_lu_bubble_rd",  32'(rd_o), 32'd0);
    chk("lit_lu_bubble_wr",  32'(reg_wr_o), 32'd0);
    step(NOPI);
    chk("lit_lu_add_rd", 32'(rd_o), 32'd6);

    // flush during the would-be stall
    step(LW5);
    drive(1'b0, 1'b1, ADD6, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("lit_fl_stall", 32'(stall_o), 32'd0);
    step(ADD6);
    chk("lit_fl_bubble_rd", 32'(rd_o), 32'd0);
    chk("lit_fl_bubble_rd_en", 32'(mem_rd_o), 32'd0);
    step(NOPI);
    chk("lit_fl_add_rd", 32'(rd_o), 32'd6);

    // illegal opcode
    step(32'h0000007F);
    step(NOPI);
    chk("lit_ill",    32'(illegal_o), 32'd1);
    chk("lit_ill_wr", 32'(reg_wr_o | mem_wr_o | mem_rd_o | branch_o | jump_o), 32'd0);
    step(NOPI);
    chk("lit_ill_clear", 32'(illegal_o), 32'd0);

    // randomized traffic; fetch holds the instruction while stalled
    ins = NOPI;
    for (int n = 0; n < 800; n++) begin
      if (!stalled) ins = gen_instr();
      drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) == 0), ins,
            $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 2) != 0),
            5'($urandom_range(0, 7)), $urandom);
    end
    drive(1'b0, 1'b0, NOPI, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
